reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU pipeline (ALU) and the multi-cycle multiply/divide unit (MD).
- Each requester gets a small queue. A round-robin arbiter with an oldest-first override drains the queues into a registered write stage that drives the register file's write enable, write address and write data.
- Publishes a pending-write mask so the issue stage can stall on read-after-write hazards against queued writebacks.

Parameters:
ADDR_W, 6, register address width; matches register file address ports.
DATA_W, 32, writeback data width.
Q_DEPTH, 2, entries per requester queue; power of two, at least 2.
TAG_W, 3, age-tag width; must satisfy 2^TAG_W > 2*Q_DEPTH+1.

Ports:
SYS_clk  in  1  system clock, rising edge.
SYS_reset_n  in  1  asynchronous active-low reset.
ALU_wb_valid  in  1  ALU writeback request.
ALU_wb_ready  out  1  ALU queue not full.
ALU_wb_addr  in  ADDR_W  ALU destination register.
ALU_wb_data  in  DATA_W  ALU result.
MD_wb_valid  in  1  MD writeback request.
MD_wb_ready  out  1  MD queue not full.
MD_wb_addr  in  ADDR_W  MD destination register.
MD_wb_data  in  DATA_W  MD result.
REG_write_1  out  1  register file write enable (registered).
REG_address_wr  out  ADDR_W  register file write address (registered).
REG_data_wb_in1  out  DATA_W  register file write data (registered).
REG_pending_mask  out  32  bit r set while a write to r is queued or in the output stage.

Behaviour:
- Clock and reset:
  - One clock, SYS_clk.
  - SYS_reset_n is asynchronous and active-low.
  - Reset clears both queues, the age counter and the output stage.
  - Reset values: REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0, REG_pending_mask=0.
  - Both ready outputs are 1 in reset and after reset.
  - Reset mid-operation discards all queued writes; nothing is written.
  - Round-robin pointer resets to "ALU next".
- Accept:
  - A requester's entry is pushed on a rising edge where valid && ready.
  - ready = queue not full, combinational from queue occupancy only (never depends on valid).
  - Each pushed entry stores {addr, data, tag}, where tag = global age counter.
  - The age counter increments (mod 2^TAG_W) once per edge with one or more pushes.
  - Simultaneous pushes share the same tag.
- Arbitrate (combinational on queue heads, one pop per cycle):
  - Only one head valid: pop it.
  - Both heads valid, same nonzero addr: pop the older tag, using wrap-aware compare ((tagA - tagB) mod 2^TAG_W, MSB set means A older). Equal tags: MD wins.
  - Otherwise: round-robin. The pointer flips to the other requester after each grant made while both heads were valid.
- Output stage:
  - On the edge that pops an entry, load REG_address_wr and REG_data_wb_in1 from it.
  - REG_write_1 = 1 for exactly one cycle, unless addr == 0. An addr-0 entry is popped but REG_write_1 = 0 and address/data hold their previous values.
  - With no pop, REG_write_1 = 0 and address/data hold.
  - The register file captures the write on the following edge.
- Latency:
  - Uncontended request accepted at edge k: REG_write_1 high during cycle k+1 to k+2; register updated at edge k+2.
  - Throughput: one write per cycle sustained.
- Pending mask: OR of decoded addresses over all valid queue entries plus the output stage while REG_write_1 = 1. Bit 0 is always 0. The mask does not include requests being pushed this cycle.
- Full queue: ready=0 and no push. Valid/addr/data must hold until accepted; the bench asserts this on requesters.
- Simultaneous push and pop on the same queue when full: ready stays 0 (ready is not a function of pop).
- Queue pointers wrap modulo Q_DEPTH. Occupancy counter is width clog2(Q_DEPTH)+1.

Decomposition:
- Package reg_wb_pkg: ADDR_W/DATA_W/TAG_W defaults, requester index constants REQ_ALU=0 and REQ_MD=1, wb_entry struct {addr, data, tag}, and function tag_older(a,b).
- Sub-module reg_wb_fifo: synchronous FIFO holding wb_entry, depth Q_DEPTH, with push/pop/full/empty/head and a valid-entry-address vector for the mask. Instantiated twice.

Test Plan:
- Reset, then ALU_wb_valid for one cycle with addr=9, data=0x55 -> REG_write_1 high exactly one cycle starting one cycle after acceptance, addr 9, data 0x55; mask bit 9 set from accept edge until write cycle ends.
- ALU and MD both push continuously (ALU addrs 1,2,3; MD addrs 4,5,6) -> writes alternate ALU,MD,ALU,MD,... starting with ALU, one per cycle, no gaps.
- ALU pushes addr 7 data 1; next cycle MD pushes addr 7 data 2 while the ALU head is still blocked -> data 1 is written before data 2; final r7 = 2 in the attached register file.
- Hold MD_wb_valid with no pops possible (ALU saturating, queue depth 2) -> MD_wb_ready drops after 2 accepts, stalls, and recovers with data intact.
- ALU push with addr=0, data=0xFFFFFFFF -> entry consumed, REG_write_1 stays 0, mask stays 0.
- Fill both queues, assert SYS_reset_n=0 mid-cycle -> outputs zero immediately (asynchronous); after release, no stale writes, readies = 1.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file writeback arbiter: entry layout,
// requester indices and the wrap-aware age comparison.
package reg_wb_pkg;

  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_TAG_W   = 3;
  localparam int DEFAULT_Q_DEPTH = 2;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MD  = 1'b1;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
    logic [DEFAULT_TAG_W-1:0]  tag;
  } wb_entry;

  // True when tag a was issued before tag b (counter wraps modulo 2^TAG_W).
  function automatic logic tag_older(input logic [DEFAULT_TAG_W-1:0] a,
                                     input logic [DEFAULT_TAG_W-1:0] b);
    logic [DEFAULT_TAG_W-1:0] diff;
    diff = a - b;
    return diff[DEFAULT_TAG_W-1];
  endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// Small synchronous FIFO of writeback entries; also reports a one-hot OR of
// the destination registers of every occupied slot.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_Q_DEPTH
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic        push,
  input  logic        pop,
  input  wb_entry     push_entry,
  output logic        full,
  output logic        empty,
  output wb_entry     head,
  output logic [31:0] addr_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry            mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [31:0]        entry_bits [DEPTH];

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem_reg[rd_ptr_reg];

  always_ff @(posedge SYS_clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset = PTR_W'(gi) - rd_ptr_reg;
    assign entry_bits[gi] = ({1'b0, offset} < count_reg) ? (32'd1 << mem_reg[gi].addr) : 32'd0;
  end

  always_comb begin
    addr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_mask = addr_mask | entry_bits[i];
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port between the ALU and MD writeback paths:
// per-requester queues, round-robin with oldest-first on same-register heads.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int Q_DEPTH = DEFAULT_Q_DEPTH,
  parameter int TAG_W   = DEFAULT_TAG_W
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              ALU_wb_valid,
  output logic              ALU_wb_ready,
  input  logic [ADDR_W-1:0] ALU_wb_addr,
  input  logic [DATA_W-1:0] ALU_wb_data,
  input  logic              MD_wb_valid,
  output logic              MD_wb_ready,
  input  logic [ADDR_W-1:0] MD_wb_addr,
  input  logic [DATA_W-1:0] MD_wb_data,
  output logic              REG_write_1,
  output logic [ADDR_W-1:0] REG_address_wr,
  output logic [DATA_W-1:0] REG_data_wb_in1,
  output logic [31:0]       REG_pending_mask
);

  wb_entry           alu_push_entry, md_push_entry, alu_head, md_head;
  logic              alu_full, alu_empty, md_full, md_empty;
  logic              alu_push, md_push, alu_pop, md_pop;
  logic [31:0]       alu_mask, md_mask;
  logic [TAG_W-1:0]  age_reg;
  logic              rr_reg;
  logic              both_heads, any_head, same_dest, grant_md;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  assign ALU_wb_ready   = ~alu_full;
  assign MD_wb_ready    = ~md_full;
  assign alu_push       = ALU_wb_valid & ~alu_full;
  assign md_push        = MD_wb_valid & ~md_full;
  assign alu_push_entry = {ALU_wb_addr, ALU_wb_data, age_reg};
  assign md_push_entry  = {MD_wb_addr, MD_wb_data, age_reg};

  reg_wb_fifo #(.DEPTH(Q_DEPTH)) u_alu_fifo (
    .SYS_clk     (SYS_clk),
    .SYS_reset_n (SYS_reset_n),
    .push        (alu_push),
    .pop         (alu_pop),
    .push_entry  (alu_push_entry),
    .full        (alu_full),
    .empty       (alu_empty),
    .head        (alu_head),
    .addr_mask   (alu_mask)
  );

  reg_wb_fifo #(.DEPTH(Q_DEPTH)) u_md_fifo (
    .SYS_clk     (SYS_clk),
    .SYS_reset_n (SYS_reset_n),
    .push        (md_push),
    .pop         (md_pop),
    .push_entry  (md_push_entry),
    .full        (md_full),
    .empty       (md_empty),
    .head        (md_head),
    .addr_mask   (md_mask)
  );

  // Same destination on both heads: the older write must land first so the
  // younger value survives in the register file. Equal tags go to MD.
  always_comb begin
    both_heads = ~alu_empty & ~md_empty;
    any_head   = ~alu_empty | ~md_empty;
    same_dest  = (alu_head.addr == md_head.addr) && (alu_head.addr != '0);
    grant_md   = 1'b0;
    if (both_heads) begin
      if (same_dest) grant_md = ~tag_older(alu_head.tag, md_head.tag);
      else           grant_md = (rr_reg == REQ_MD);
    end else begin
      grant_md = ~md_empty;
    end
  end

  assign alu_pop    = any_head & ~grant_md;
  assign md_pop     = grant_md;
  assign grant_addr = grant_md ? md_head.addr : alu_head.addr;
  assign grant_data = grant_md ? md_head.data : alu_head.data;

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      age_reg   <= '0;
      rr_reg    <= REQ_ALU;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      if (alu_push | md_push) age_reg <= age_reg + 1'b1;
      if (both_heads) rr_reg <= grant_md ? REQ_ALU : REQ_MD;
      write_reg <= 1'b0;
      if (any_head && (grant_addr != '0)) begin
        write_reg <= 1'b1;
        addr_reg  <= grant_addr;
        data_reg  <= grant_data;
      end
    end
  end

  assign REG_write_1      = write_reg;
  assign REG_address_wr   = addr_reg;
  assign REG_data_wb_in1  = data_reg;
  assign REG_pending_mask = (alu_mask | md_mask | (write_reg ? (32'd1 << addr_reg) : 32'd0)) & ~32'd1;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, hand-written
// ordering/stall/reset sequences and random traffic against a queue model.
module tb_reg_wb_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int QD = 2;
  localparam int TAG_MOD = 8;

  logic          SYS_clk = 1'b0;
  logic          SYS_reset_n = 1'b0;
  logic          ALU_wb_valid = 1'b0, MD_wb_valid = 1'b0;
  logic [AW-1:0] ALU_wb_addr = '0, MD_wb_addr = '0;
  logic [DW-1:0] ALU_wb_data = '0, MD_wb_data = '0;
  logic          ALU_wb_ready, MD_wb_ready, REG_write_1;
  logic [AW-1:0] REG_address_wr;
  logic [DW-1:0] REG_data_wb_in1;
  logic [31:0]   REG_pending_mask;

  always #5 SYS_clk = ~SYS_clk;

  reg_wb_arbiter dut (
    .SYS_clk          (SYS_clk),
    .SYS_reset_n      (SYS_reset_n),
    .ALU_wb_valid     (ALU_wb_valid),
    .ALU_wb_ready     (ALU_wb_ready),
    .ALU_wb_addr      (ALU_wb_addr),
    .ALU_wb_data      (ALU_wb_data),
    .MD_wb_valid      (MD_wb_valid),
    .MD_wb_ready      (MD_wb_ready),
    .MD_wb_addr       (MD_wb_addr),
    .MD_wb_data       (MD_wb_data),
    .REG_write_1      (REG_write_1),
    .REG_address_wr   (REG_address_wr),
    .REG_data_wb_in1  (REG_data_wb_in1),
    .REG_pending_mask (REG_pending_mask)
  );

  // Requesters must hold a refused request unchanged.
  a_alu_hold: assert property (@(posedge SYS_clk) disable iff (!SYS_reset_n)
    (ALU_wb_valid && !ALU_wb_ready) |=> (ALU_wb_valid && $stable(ALU_wb_addr) && $stable(ALU_wb_data)));
  a_md_hold: assert property (@(posedge SYS_clk) disable iff (!SYS_reset_n)
    (MD_wb_valid && !MD_wb_ready) |=> (MD_wb_valid && $stable(MD_wb_addr) && $stable(MD_wb_data)));

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: two FIFOs of pending writes, an age counter, the
  // round-robin preference and the write stage contents.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            tag;
  } m_ent_t;

  m_ent_t        mq_alu[$];
  m_ent_t        mq_md[$];
  int            m_age;
  bit            m_rr_md;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rf [64];

  task automatic model_reset();
    mq_alu.delete();
    mq_md.delete();
    m_age = 0; m_rr_md = 0; m_wr = 0; m_addr = '0; m_data = '0;
  endtask

  function automatic bit alu_is_older(int ta, int tm);
    return (((ta - tm) % TAG_MOD + TAG_MOD) % TAG_MOD) >= TAG_MOD / 2;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq_alu[i]) if (mq_alu[i].addr < 32) m[mq_alu[i].addr[4:0]] = 1'b1;
    foreach (mq_md[i])  if (mq_md[i].addr < 32)  m[mq_md[i].addr[4:0]] = 1'b1;
    if (m_wr && m_addr < 32) m[m_addr[4:0]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_edge(input bit pa, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input bit pm, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bit     pick_md;
    m_ent_t e;
    m_wr = 0;
    if (mq_alu.size() > 0 || mq_md.size() > 0) begin
      if (mq_alu.size() > 0 && mq_md.size() > 0) begin
        if (mq_alu[0].addr == mq_md[0].addr && mq_alu[0].addr != 0)
          pick_md = !alu_is_older(mq_alu[0].tag, mq_md[0].tag);
        else
          pick_md = m_rr_md;
        m_rr_md = !pick_md;
      end else begin
        pick_md = (mq_md.size() > 0);
      end
      if (pick_md) e = mq_md.pop_front();
      else         e = mq_alu.pop_front();
      if (e.addr != 0) begin
        m_wr = 1; m_addr = e.addr; m_data = e.data;
      end
    end
    if (pa) mq_alu.push_back('{aa, ad, m_age});
    if (pm) mq_md.push_back('{ma, md, m_age});
    if (pa || pm) m_age = (m_age + 1) % TAG_MOD;
  endtask

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ar;
    logic          mr;
    logic [31:0]   m;
  } obs_t;

  // One clock: drive inputs, compare outputs with the model mid-cycle,
  // then advance the model and the attached register file at the edge.
  task automatic cycle(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] mdd,
                       output bit acc_a, output bit acc_m, output obs_t o);
    ALU_wb_valid = av; ALU_wb_addr = aa; ALU_wb_data = ad;
    MD_wb_valid  = mv; MD_wb_addr  = ma; MD_wb_data  = mdd;
    @(negedge SYS_clk);
    o = {REG_write_1, REG_address_wr, REG_data_wb_in1, ALU_wb_ready, MD_wb_ready, REG_pending_mask};
    acc_a = av && (mq_alu.size() < QD);
    acc_m = mv && (mq_md.size() < QD);
    chk("alu_ready", o.ar, mq_alu.size() < QD);
    chk("md_ready", o.mr, mq_md.size() < QD);
    chk("write_en", o.w, m_wr);
    chk("write_addr", o.a, m_addr);
    chk("write_data", o.d, m_data);
    chk("pending_mask", o.m, model_mask());
    @(posedge SYS_clk);
    if (o.w) rf[o.a] = o.d;
    model_edge(acc_a, aa, ad, acc_m, ma, mdd);
    #1;
  endtask

  bit   g_acc_a, g_acc_m;
  obs_t g_o;

  task automatic idle(input int n);
    bit   x, y;
    obs_t o;
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, x, y, o);
  endtask

  // Random requesters honouring the hold rule; pa/pm are request percentages.
  task automatic run_rand(input int n, input int pa, input int pm, input int amax, output int md_stalls);
    bit            av = 0, mv = 0, acc_a, acc_m;
    logic [AW-1:0] aa = '0, ma = '0;
    logic [DW-1:0] ad = '0, mdd = '0;
    obs_t          o;
    md_stalls = 0;
    for (int c = 0; c < n; c++) begin
      if (!av && $urandom_range(99) < pa) begin
        av = 1; aa = AW'($urandom_range(amax)); ad = $urandom;
      end
      if (!mv && $urandom_range(99) < pm) begin
        mv = 1; ma = AW'($urandom_range(amax)); mdd = $urandom;
      end
      cycle(av, aa, ad, mv, ma, mdd, acc_a, acc_m, o);
      if (mv && !acc_m) md_stalls++;
      if (acc_a) av = 0;
      if (acc_m) mv = 0;
    end
    for (int g = 0; g < 20 && (av || mv); g++) begin
      cycle(av, aa, ad, mv, ma, mdd, acc_a, acc_m, o);
      if (acc_a) av = 0;
      if (acc_m) mv = 0;
    end
    if (av || mv) chk("drain_timeout", 1, 0);
    idle(6);
  endtask

  typedef struct {
    bit            av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    bit            mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    bit            ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ear;
    bit            emr;
    logic [31:0]   em;
  } vec_t;

  function automatic vec_t mk(bit av, int aa, logic [DW-1:0] ad, bit mv, int ma, logic [DW-1:0] md,
                              bit ew, int ea, logic [DW-1:0] ed, bit ear, bit emr, logic [31:0] em);
    vec_t v;
    v.av = av; v.aa = AW'(aa); v.ad = ad; v.mv = mv; v.ma = AW'(ma); v.md = md;
    v.ew = ew; v.ea = AW'(ea); v.ed = ed; v.ear = ear; v.emr = emr; v.em = em;
    return v;
  endfunction

  vec_t tbl [16];
  int   stalls;

  initial begin
    // single write (addr 9), addr-0 write, then both requesters streaming
    tbl[0]  = mk(1, 9, 32'h55, 0, 0, 0,            0, 0, 32'h0,  1, 1, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,                 0, 0, 32'h0,  1, 1, 32'h200);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,                 1, 9, 32'h55, 1, 1, 32'h200);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,                 0, 9, 32'h55, 1, 1, 32'h0);
    tbl[4]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,     0, 9, 32'h55, 1, 1, 32'h0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,                 0, 9, 32'h55, 1, 1, 32'h0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,                 0, 9, 32'h55, 1, 1, 32'h0);
    tbl[7]  = mk(1, 1, 32'h11, 1, 4, 32'h44,       0, 9, 32'h55, 1, 1, 32'h0);
    tbl[8]  = mk(1, 2, 32'h22, 1, 5, 32'h55,       0, 9, 32'h55, 1, 1, 32'h12);
    tbl[9]  = mk(1, 3, 32'h33, 1, 6, 32'h66,       1, 1, 32'h11, 1, 0, 32'h36);
    tbl[10] = mk(0, 0, 0, 1, 6, 32'h66,            1, 4, 32'h44, 0, 1, 32'h3C);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,                 1, 2, 32'h22, 1, 0, 32'h6C);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,                 1, 5, 32'h55, 1, 1, 32'h68);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,                 1, 3, 32'h33, 1, 1, 32'h48);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,                 1, 6, 32'h66, 1, 1, 32'h40);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,                 0, 6, 32'h66, 1, 1, 32'h0);

    foreach (rf[i]) rf[i] = '0;
    model_reset();

    #12;
    chk("rst_write", REG_write_1, 0);
    chk("rst_addr", REG_address_wr, 0);
    chk("rst_data", REG_data_wb_in1, 0);
    chk("rst_mask", REG_pending_mask, 0);
    chk("rst_ready", {ALU_wb_ready, MD_wb_ready}, 2'b11);
    @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    @(posedge SYS_clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md, g_acc_a, g_acc_m, g_o);
      $display("vec %0d: write=%0d addr=%0d data=0x%0h ready=%0d%0d mask=0x%0h", i, g_o.w, g_o.a, g_o.d, g_o.ar, g_o.mr, g_o.m);
      chk($sformatf("tbl%0d_write", i), g_o.w, tbl[i].ew);
      chk($sformatf("tbl%0d_addr", i), g_o.a, tbl[i].ea);
      chk($sformatf("tbl%0d_data", i), g_o.d, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), {g_o.ar, g_o.mr}, {tbl[i].ear, tbl[i].emr});
      chk($sformatf("tbl%0d_mask", i), g_o.m, tbl[i].em);
    end
    chk("rf9", rf[9], 32'h55);
    for (int r = 1; r <= 6; r++) chk($sformatf("rf%0d", r), rf[r], 32'h11 * r);

    // ALU writes r7=1, MD writes r7=2 a cycle later: the younger value must survive
    cycle(1, 6'd20, 32'hA, 1, 6'd21, 32'hB, g_acc_a, g_acc_m, g_o);
    cycle(1, 6'd7, 32'h1, 0, '0, '0, g_acc_a, g_acc_m, g_o);
    cycle(0, '0, '0, 1, 6'd7, 32'h2, g_acc_a, g_acc_m, g_o);
    idle(6);
    $display("r7 after ordered writes = 0x%0h", rf[7]);
    chk("rf7_order", rf[7], 32'h2);

    // both requesters saturating: MD must be back-pressured and recover
    run_rand(12, 100, 100, 31, stalls);
    $display("saturation: md stall cycles = %0d", stalls);
    chk("md_stall_seen", stalls > 0, 1);

    // random traffic on a few registers to provoke same-destination heads
    run_rand(400, 70, 60, 5, stalls);
    $display("random phase done, md stall cycles = %0d", stalls);

    // asynchronous reset with both queues loaded
    cycle(1, 6'd20, 32'h20, 1, 6'd21, 32'h21, g_acc_a, g_acc_m, g_o);
    cycle(1, 6'd22, 32'h22, 1, 6'd23, 32'h23, g_acc_a, g_acc_m, g_o);
    ALU_wb_valid = 1'b0;
    MD_wb_valid  = 1'b0;
    #2;
    SYS_reset_n = 1'b0;
    #1;
    $display("async reset: write=%0d addr=%0d data=0x%0h mask=0x%0h", REG_write_1, REG_address_wr, REG_data_wb_in1, REG_pending_mask);
    chk("arst_write", REG_write_1, 0);
    chk("arst_addr", REG_address_wr, 0);
    chk("arst_data", REG_data_wb_in1, 0);
    chk("arst_mask", REG_pending_mask, 0);
    chk("arst_ready", {ALU_wb_ready, MD_wb_ready}, 2'b11);
    model_reset();
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    @(posedge SYS_clk);
    #1;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
